snowv_ks_xor: RTL and testbench
===============================

# snowv_ks_xor

Downstream consumer of the SNOW-V keystream generator. The block buffers the 128-bit keystream words `z` in a small FIFO, because the generator streams words on `valid` with no backpressure. It XORs each buffered word with one 128-bit block of a ready/valid data stream to produce the ciphertext or plaintext stream. It also keeps overflow and block-count status for the control layer.

## Interface
- `DEPTH`, default 8: keystream FIFO depth in 128-bit words. Power of two, ≥2.
- `LVL_W`, default 4: width of `ks_level`. Equals log2(`DEPTH`)+1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset. This is the block's only reset.
- `ks_z` in 128: keystream word from the generator.
- `ks_valid` in 1: `ks_z` is valid this cycle. There is no ready signal back to the generator.
- `ks_flush` in 1: one-cycle pulse that empties the FIFO. Used on rekey or new IV.
- `ks_level` out LVL_W: number of buffered keystream words.
- `ks_overflow` out 1: sticky; set when a keystream word is dropped.
- `ovf_clr` in 1: clears `ks_overflow`.
- `in_data` in 128: input block.
- `in_keep` in 16: byte enables; bit i covers bits [8i+7:8i].
- `in_last` in 1: last block of the message.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `out_data` out 128, `out_keep` out 16, `out_last` out 1: output block.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `blk_cnt` out 32: count of blocks transferred on the input side. Wraps modulo 2^32.

## Operation
- **FIFO push.** A word is pushed when `ks_valid` is high and the FIFO is not full.
  - A push into a full FIFO is also accepted if a pop happens in the same cycle.
  - Otherwise the word is dropped and `ks_overflow` is set.
- **Flush.**
  - `ks_flush` sets the read pointer, write pointer and level to 0.
  - Flush overrides a simultaneous push or pop. The pushed word is discarded and `ks_overflow` is not set.
  - Flush does not touch the output register, `blk_cnt` or `ks_overflow`.
- **Overflow clear.** `ovf_clr` clears `ks_overflow`. If a drop happens in the same cycle as `ovf_clr`, the set wins.
- **Ready.** `in_ready` = (level ≠ 0) AND (!`out_valid` OR `out_ready`). It is combinational and does not depend on `in_valid`.
- **Transfer.** An input transfer is `in_valid` AND `in_ready`. On a transfer:
  - Pop the FIFO head H.
  - Load `out_data` ← `in_data` ^ H; `out_keep` ← `in_keep`; `out_last` ← `in_last`.
  - Set `out_valid` to 1 and increment `blk_cnt`.
- **Output drain.** If `out_valid` and `out_ready` are high and there is no new transfer, `out_valid` clears.
- **Partial blocks.** Each block consumes one whole keystream word, including partial blocks (`in_keep` ≠ FFFF). Unused keystream bytes are discarded.
- **`in_last`.** Passes through only; it has no effect on the FIFO.

## Timing
- **Reset values.** Level 0, `ks_level` 0, `ks_overflow` 0, `out_valid` 0, `out_data` 0, `out_keep` 0, `out_last` 0, `blk_cnt` 0.
  - `in_ready` is 0 after reset because the FIFO is empty.
  - A reset mid-stream drops all buffered words and any pending output block.
- **Data latency.** One cycle from the input transfer to `out_valid` high.
- **Keystream latency.** A word pushed in cycle N can be popped in cycle N+1. There is no push-to-pop bypass within the same cycle.
- **Throughput.** One block per cycle when `out_ready` is held high and the FIFO is non-empty.
- **`ks_level`.** Registered; reflects pushes and pops of the previous edge. Full is `ks_level` = `DEPTH`.
- **Pointers.** Wrap modulo `DEPTH`.
- **Output stability.** While `out_valid` is high and `out_ready` is low, all output fields hold stable.

## Configuration
- **`SNOWV_XOR_KEEP_MASK_EN` defined:** output bytes whose `in_keep` bit is 0 are forced to 0x00 in `out_data`.
- **`SNOWV_XOR_KEEP_MASK_EN` undefined:** every byte is `in_data` ^ H regardless of keep. `out_keep` is still passed through.

## Test plan
1. **Basic XOR.**
   - Stimulus: after reset, push `ks_z` = FFFF…FF, then drive `in_data` = 0123456789ABCDEF0011223344556677 with keep FFFF.
   - Response: `out_data` = FEDCBA9876543210FFEEDDCCBBAA9988, `out_valid` one cycle after the transfer, `blk_cnt` = 1.
2. **Empty stall.**
   - Stimulus: `in_valid` high with the FIFO empty.
   - Response: `in_ready` = 0 and no output. A push in cycle N gives `in_ready` = 1 in cycle N+1.
3. **Overflow.**
   - Stimulus: push `DEPTH`+1 words (`DEPTH`=8) with no pops.
   - Response: `ks_level` = 8 and `ks_overflow` = 1. Draining yields the first 8 words in order. `ovf_clr` clears the flag.
4. **Full with simultaneous pop.**
   - Stimulus: full FIFO, one push and one transfer in the same cycle.
   - Response: `ks_level` stays 8 and `ks_overflow` stays 0.
5. **Backpressure.**
   - Stimulus: hold `out_ready` = 0 for 5 cycles with data pending.
   - Response: output fields stay stable, `in_ready` = 0, FIFO level unchanged. Exactly one block per `out_ready` cycle afterwards.
6. **Flush and keep mask.**
   - Stimulus: `ks_flush` together with `ks_valid` gives `ks_level` = 0. Then, with the macro defined, send keep 000F with data 0 and `ks_z` = AAAA…AA.
   - Response: after the flush, `ks_overflow` = 0. With the mask, `out_data` = 000…00AAAAAAAA.

Source files
------------

// File: rtl/snowv_ks_xor.sv
// snowv_ks_xor: SNOW-V keystream FIFO XORed onto a ready/valid block stream; SNOWV_XOR_KEEP_MASK_EN zeroes unkept output bytes
module snowv_ks_xor #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     ks_z,
  input  logic             ks_valid,
  input  logic             ks_flush,
  output logic [LVL_W-1:0] ks_level,
  output logic             ks_overflow,
  input  logic             ovf_clr,
  input  logic [127:0]     in_data,
  input  logic [15:0]      in_keep,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [127:0]     out_data,
  output logic [15:0]      out_keep,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      blk_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [127:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic ovf_q, ovf_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [127:0] out_data_q, out_data_d, mask;
  logic [15:0] out_keep_q, out_keep_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic full, pop, push, drop;
  always_comb begin
    full = level_q == LVL_W'(DEPTH);
    in_ready = (level_q != '0) && (!out_valid_q || out_ready);
    pop = in_valid && in_ready;
    // a pop frees a slot in the same cycle, so a full FIFO still accepts the word
    push = ks_valid && (!full || pop) && !ks_flush;
    drop = ks_valid && full && !pop && !ks_flush;
    mask = '1;
`ifdef SNOWV_XOR_KEEP_MASK_EN
    for (int i = 0; i < 16; i++) mask[8*i +: 8] = {8{in_keep[i]}};
`endif
    rd_ptr_d = ks_flush ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = ks_flush ? '0 : wr_ptr_q + AW'(push);
    level_d = ks_flush ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d = drop || (ovf_q && !ovf_clr);
    out_valid_d = pop || (out_valid_q && !out_ready);
    out_data_d = pop ? (in_data ^ mem_q[rd_ptr_q]) & mask : out_data_q;
    out_keep_d = pop ? in_keep : out_keep_q;
    out_last_d = pop ? in_last : out_last_q;
    blk_cnt_d = blk_cnt_q + 32'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= ks_z;
  assign ks_level = level_q;
  assign ks_overflow = ovf_q;
  assign out_data = out_data_q;
  assign out_keep = out_keep_q;
  assign out_last = out_last_q;
  assign out_valid = out_valid_q;
  assign blk_cnt = blk_cnt_q;
endmodule

// File: tb/tb_snowv_ks_xor.sv
// tb_snowv_ks_xor: directed stimulus checked every cycle against a queue model plus literal expectations
module tb_snowv_ks_xor;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1;
  logic [127:0] ks_z = '0, in_data = '0, out_data;
  logic ks_valid = 0, ks_flush = 0, ovf_clr = 0, in_last = 0, in_valid = 0, out_ready = 1;
  logic [15:0] in_keep = '0, out_keep;
  logic [3:0] ks_level;
  logic ks_overflow, in_ready, out_last, out_valid;
  logic [31:0] blk_cnt;
  int n_chk = 0, n_fail = 0;
  logic [127:0] q[$];
  logic m_ovf = 0, m_ov = 0, m_ol = 0, started = 0;
  logic [127:0] m_od = '0;
  logic [15:0] m_ok = '0;
  int m_bc = 0;

  snowv_ks_xor dut (.clk(clk), .rst(rst), .ks_z(ks_z), .ks_valid(ks_valid), .ks_flush(ks_flush),
    .ks_level(ks_level), .ks_overflow(ks_overflow), .ovf_clr(ovf_clr), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .blk_cnt(blk_cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_rdy();
    return q.size() != 0 && (!m_ov || out_ready);
  endfunction

  always @(posedge clk) begin
    logic xfer;
    logic [127:0] h;
    started = 1;
    if (rst) begin
      q.delete(); m_ovf = 0; m_ov = 0; m_od = '0; m_ok = '0; m_ol = 0; m_bc = 0;
    end else begin
      xfer = in_valid && m_rdy();
      if (xfer) begin
        h = q[0];
        m_od = in_data ^ h;
`ifdef SNOWV_XOR_KEEP_MASK_EN
        for (int i = 0; i < 16; i++) if (!in_keep[i]) m_od[8*i +: 8] = 8'h00;
`endif
        m_ok = in_keep; m_ol = in_last; m_ov = 1; m_bc++;
      end else if (out_ready) m_ov = 0;
      if (ovf_clr) m_ovf = 0;
      if (ks_flush) q.delete();
      else begin
        if (xfer) void'(q.pop_front());
        if (ks_valid) begin
          if (q.size() < DEPTH) q.push_back(ks_z);
          else m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (started) begin
      check("ks_level", 128'(ks_level), 128'(q.size()));
      check("ks_overflow", 128'(ks_overflow), 128'(m_ovf));
      check("in_ready", 128'(in_ready), 128'(m_rdy()));
      check("out_valid", 128'(out_valid), 128'(m_ov));
      check("blk_cnt", 128'(blk_cnt), 128'(m_bc));
      if (m_ov) begin
        check("out_data", out_data, m_od);
        check("out_keep", 128'(out_keep), 128'(m_ok));
        check("out_last", 128'(out_last), 128'(m_ol));
      end
    end
  end

  task automatic step(input logic kv, input logic [127:0] kz, input logic iv, input logic [127:0] id,
                      input logic [15:0] ik = 16'hFFFF, input logic orr = 1, input logic fl = 0, input logic oc = 0);
    ks_valid = kv; ks_z = kz; in_valid = iv; in_data = id; in_keep = ik; in_last = iv && ik != 16'hFFFF;
    out_ready = orr; ks_flush = fl; ovf_clr = oc;
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] w(input int i);
    return {4{32'h1000_0000 + i}};
  endfunction

  initial begin
    rst = 1;
    step(0, '0, 0, '0);
    step(0, '0, 0, '0);
    check("reset level", 128'(ks_level), 0);
    check("reset out_valid", 128'(out_valid), 0);
    check("reset in_ready", 128'(in_ready), 0);
    check("reset out_data", out_data, 0);
    rst = 0;
    step(1, '1, 0, '0);
    check("t1 level", 128'(ks_level), 1);
    step(0, '0, 1, 128'h0123456789ABCDEF0011223344556677);
    check("t1 out_data", out_data, 128'hFEDCBA9876543210FFEEDDCCBBAA9988);
    check("t1 out_valid", 128'(out_valid), 1);
    check("t1 blk_cnt", 128'(blk_cnt), 1);
    step(0, '0, 0, '0);
    step(0, '0, 1, '1);
    check("t2 empty in_ready", 128'(in_ready), 0);
    check("t2 empty out_valid", 128'(out_valid), 0);
    step(1, 128'h5, 1, '1);
    check("t2 ready after push", 128'(in_ready), 1);
    step(0, '0, 1, '1);
    check("t2 out_data", out_data, ~128'h5);
    step(0, '0, 0, '0);
    for (int i = 0; i <= DEPTH; i++) step(1, w(i), 0, '0);
    check("t3 level", 128'(ks_level), 8);
    check("t3 overflow", 128'(ks_overflow), 1);
    step(0, '0, 1, '0);
    check("t3 first word", out_data, w(0));
    for (int i = 1; i < DEPTH; i++) step(0, '0, 1, '0);
    check("t3 last word", out_data, w(7));
    step(0, '0, 0, '0, 16'hFFFF, 1, 0, 1);
    check("t3 ovf_clr", 128'(ks_overflow), 0);
    for (int i = 0; i < DEPTH; i++) step(1, w(20 + i), 0, '0);
    step(1, w(40), 1, '0);
    check("t4 level", 128'(ks_level), 8);
    check("t4 overflow", 128'(ks_overflow), 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, '0);
    check("t4 tail word", out_data, w(40));
    step(0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, w(60 + i), 0, '0);
    step(0, '0, 1, 128'h1);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 128'h2, 16'hFFFF, 0);
    check("t5 held data", out_data, w(60) ^ 128'h1);
    check("t5 level", 128'(ks_level), 2);
    check("t5 in_ready", 128'(in_ready), 0);
    step(0, '0, 1, 128'h2);
    check("t5 next block", out_data, w(61) ^ 128'h2);
    step(0, '0, 1, 128'h3);
    check("t5 third block", out_data, w(62) ^ 128'h3);
    step(0, '0, 0, '0);
    step(1, w(80), 0, '0);
    step(1, w(81), 0, '0);
    step(1, w(82), 0, '0, 16'hFFFF, 1, 1);
    check("t6 flush level", 128'(ks_level), 0);
    check("t6 flush overflow", 128'(ks_overflow), 0);
    step(1, {16{8'hAA}}, 0, '0);
    step(0, '0, 1, '0, 16'h000F);
`ifdef SNOWV_XOR_KEEP_MASK_EN
    check("t6 masked data", out_data, 128'h0000000000000000_00000000AAAAAAAA);
`else
    check("t6 unmasked data", out_data, {16{8'hAA}});
`endif
    check("t6 out_keep", 128'(out_keep), 128'h000F);
    check("t6 out_last", 128'(out_last), 1);
    check("final blk_cnt", 128'(blk_cnt), 23);
    step(0, '0, 0, '0);
    step(0, '0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
